// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one unified memory port between the multicycle CPU
// (port 0) and a DMA/boot-loader requester (port 1).
// Round-robin with a bounded burst: a port that keeps winning while the
// other port waits is limited to MAX_BURST consecutive grants.
// Reads return one cycle after the grant with a per-port valid flag.
// Optional build macro ARB_PERF_CNT_EN adds saturating per-port wait
// counters (cpu_wait_cnt, dma_wait_cnt). Arbitration is the same either way.
module mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       cpu_wait_cnt,
    output logic [31:0]       dma_wait_cnt
`endif
);

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DMA = 1'b1
    } port_e;

    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    port_e      lastPort_q, lastPort_d;
    logic [3:0] burstCnt_q, burstCnt_d;
    logic       rdPendCpu_q, rdPendDma_q;

    logic       cpuWin, dmaWin, anyWin;
    logic       streakOpen;
    port_e      winPort;

    // A streak may continue only if it has started and has not hit the cap.
    assign streakOpen = (burstCnt_q != 4'd0) && (burstCnt_q < BURST_MAX);
    assign anyWin     = cpuWin | dmaWin;
    assign winPort    = dmaWin ? PORT_DMA : PORT_CPU;

    // Choose at most one winner; nobody wins while reset is asserted.
    always_comb begin
        cpuWin = 1'b0;
        dmaWin = 1'b0;
        if (!reset) begin
            if (cpu_req && dma_req) begin
                if (streakOpen) begin
                    cpuWin = (lastPort_q == PORT_CPU);
                    dmaWin = (lastPort_q == PORT_DMA);
                end else begin
                    cpuWin = (lastPort_q == PORT_DMA);
                    dmaWin = (lastPort_q == PORT_CPU);
                end
            end else begin
                cpuWin = cpu_req;
                dmaWin = dma_req;
            end
        end
    end

    // Next round-robin pointer and streak length; an idle cycle ends the streak.
    always_comb begin
        lastPort_d = lastPort_q;
        burstCnt_d = burstCnt_q;
        if (!anyWin) begin
            burstCnt_d = 4'd0;
        end else if (winPort == lastPort_q) begin
            burstCnt_d = (burstCnt_q >= BURST_MAX) ? BURST_MAX : burstCnt_q + 4'd1;
        end else begin
            lastPort_d = winPort;
            burstCnt_d = 4'd1;
        end
    end

    // Arbitration state and read-pending flags; reset drops any in-flight read.
    always_ff @(posedge clock) begin
        if (reset) begin
            lastPort_q  <= PORT_DMA;
            burstCnt_q  <= 4'd0;
            rdPendCpu_q <= 1'b0;
            rdPendDma_q <= 1'b0;
        end else begin
            lastPort_q  <= lastPort_d;
            burstCnt_q  <= burstCnt_d;
            rdPendCpu_q <= cpuWin & ~cpu_we;
            rdPendDma_q <= dmaWin & ~dma_we;
        end
    end

    // Route the winning port onto the memory bus; drive zeros when idle.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (cpuWin) begin
            mem_addr  = cpu_addr;
            mem_we    = cpu_we;
            mem_wdata = cpu_wdata;
        end else if (dmaWin) begin
            mem_addr  = dma_addr;
            mem_we    = dma_we;
            mem_wdata = dma_wdata;
        end
    end

    assign cpu_gnt    = cpuWin;
    assign dma_gnt    = dmaWin;
    assign cpu_stall  = cpu_req & ~cpuWin;
    assign cpu_rvalid = rdPendCpu_q & ~reset;
    assign dma_rvalid = rdPendDma_q & ~reset;
    assign rdata      = mem_rdata;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] cpuWait_q, dmaWait_q;

    // Count cycles each port spends requesting without a grant, saturating.
    always_ff @(posedge clock) begin
        if (reset) begin
            cpuWait_q <= 32'd0;
            dmaWait_q <= 32'd0;
        end else begin
            if (cpu_req && !cpuWin && (cpuWait_q != 32'hFFFF_FFFF)) begin
                cpuWait_q <= cpuWait_q + 32'd1;
            end
            if (dma_req && !dmaWin && (dmaWait_q != 32'hFFFF_FFFF)) begin
                dmaWait_q <= dmaWait_q + 32'd1;
            end
        end
    end

    assign cpu_wait_cnt = cpuWait_q;
    assign dma_wait_cnt = dmaWait_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus a randomized run of mem_arbiter,
// checked against a history-based arbitration model and a reference memory.
module tb_mem_arbiter;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int MAX_BURST = 4;
    localparam int MEM_WORDS = 1024;

    logic              clock;
    logic              reset;
    logic              cpu_req, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt, cpu_stall, cpu_rvalid;
    logic              dma_req, dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt, dma_rvalid;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
`ifdef ARB_PERF_CNT_EN
    logic [31:0]       cpu_wait_cnt, dma_wait_cnt;
`endif

    int compared;
    int mismatched;

    logic        initEn, loadEn;
    logic [9:0]  loadAddr;
    logic [31:0] loadData;
    logic [31:0] memArr [0:MEM_WORDS-1];
    logic [31:0] refMem [0:MEM_WORDS-1];

    // Winner of every cycle since the last reset: 0 = CPU, 1 = DMA, -1 = idle.
    int hist[$];

    mem_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clock(clock),
        .reset(reset),
        .cpu_req(cpu_req),
        .cpu_we(cpu_we),
        .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt),
        .cpu_stall(cpu_stall),
        .cpu_rvalid(cpu_rvalid),
        .dma_req(dma_req),
        .dma_we(dma_we),
        .dma_addr(dma_addr),
        .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt),
        .dma_rvalid(dma_rvalid),
        .rdata(rdata),
        .mem_addr(mem_addr),
        .mem_we(mem_we),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
`ifdef ARB_PERF_CNT_EN
        ,
        .cpu_wait_cnt(cpu_wait_cnt),
        .dma_wait_cnt(dma_wait_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] initPattern(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    // Synchronous memory with one-cycle read latency and a bench-side load port.
    always @(posedge clock) begin
        if (initEn) begin
            for (int i = 0; i < MEM_WORDS; i++) memArr[i] <= initPattern(i);
        end else begin
            if (loadEn) memArr[loadAddr] <= loadData;
            if (mem_we) memArr[mem_addr[9:0]] <= mem_wdata;
        end
        mem_rdata <= memArr[mem_addr[9:0]];
    end

    function automatic int modelLast();
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] >= 0) return hist[i];
        end
        return 1;
    endfunction

    function automatic int modelStreak();
        int n;
        int p;
        n = 0;
        if (hist.size() == 0) return 0;
        p = hist[hist.size() - 1];
        if (p < 0) return 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != p) break;
            n++;
        end
        return n;
    endfunction

    function automatic int modelWinner(input bit c, input bit d);
        int s;
        if (!c && !d) return -1;
        if (c && !d) return 0;
        if (d && !c) return 1;
        s = modelStreak();
        if (s > 0 && s < MAX_BURST) return modelLast();
        return 1 - modelLast();
    endfunction

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idleInputs();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    endtask

    task automatic applyReset(input bit initMem);
        idleInputs();
        reset  = 1'b1;
        initEn = initMem;
        nextCycle();
        reset  = 1'b0;
        initEn = 1'b0;
        hist.delete();
        if (initMem) begin
            for (int i = 0; i < MEM_WORDS; i++) refMem[i] = initPattern(i);
        end
    endtask

    task automatic loadWord(input logic [9:0] a, input logic [31:0] d);
        loadEn   = 1'b1;
        loadAddr = a;
        loadData = d;
        nextCycle();
        loadEn   = 1'b0;
        refMem[a] = d;
    endtask

    task automatic test_reset();
        reset = 1'b1; initEn = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_03FC; cpu_wdata = 32'h1111_2222;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h0000_0008; dma_wdata = 32'h3333_4444;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            compared++; if (cpu_gnt !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_cpu_gnt: got %b expected 0", cpu_gnt); end
            compared++; if (dma_gnt !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_dma_gnt: got %b expected 0", dma_gnt); end
            compared++; if (mem_we !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_mem_we: got %b expected 0", mem_we); end
            compared++; if (cpu_rvalid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_cpu_rvalid: got %b expected 0", cpu_rvalid); end
            compared++; if (dma_rvalid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_dma_rvalid: got %b expected 0", dma_rvalid); end
            compared++; if (cpu_stall !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_cpu_stall: got %b expected 1", cpu_stall); end
            nextCycle();
            initEn = 1'b0;
        end
        reset = 1'b0;
        for (int i = 0; i < MEM_WORDS; i++) refMem[i] = initPattern(i);
        @(negedge clock);
        compared++; if (cpu_gnt !== 1'b1) begin mismatched++; $display("[TB] FAIL first_cpu_gnt: got %b expected 1", cpu_gnt); end
        compared++; if (dma_gnt !== 1'b0) begin mismatched++; $display("[TB] FAIL first_dma_gnt: got %b expected 0", dma_gnt); end
        compared++; if (mem_addr !== 32'h0000_03FC) begin mismatched++; $display("[TB] FAIL first_mem_addr: got %h expected 000003fc", mem_addr); end
        refMem[10'h3FC] = 32'h1111_2222;
        nextCycle();
        idleInputs();
    endtask

    task automatic test_cpu_read();
        applyReset(1'b0);
        loadWord(10'h100, 32'h1234_5678);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0100;
        @(negedge clock);
        compared++; if (cpu_gnt !== 1'b1) begin mismatched++; $display("[TB] FAIL rd_cpu_gnt: got %b expected 1", cpu_gnt); end
        compared++; if (mem_addr !== 32'h0000_0100) begin mismatched++; $display("[TB] FAIL rd_mem_addr: got %h expected 00000100", mem_addr); end
        compared++; if (mem_we !== 1'b0) begin mismatched++; $display("[TB] FAIL rd_mem_we: got %b expected 0", mem_we); end
        compared++; if (cpu_stall !== 1'b0) begin mismatched++; $display("[TB] FAIL rd_cpu_stall: got %b expected 0", cpu_stall); end
        nextCycle();
        cpu_req = 1'b0;
        @(negedge clock);
        compared++; if (cpu_rvalid !== 1'b1) begin mismatched++; $display("[TB] FAIL rd_cpu_rvalid: got %b expected 1", cpu_rvalid); end
        compared++; if (rdata !== 32'h1234_5678) begin mismatched++; $display("[TB] FAIL rd_rdata: got %h expected 12345678", rdata); end
        compared++; if (dma_rvalid !== 1'b0) begin mismatched++; $display("[TB] FAIL rd_dma_rvalid: got %b expected 0", dma_rvalid); end
        nextCycle();
        idleInputs();
    endtask

    task automatic test_round_robin();
        bit expCpu;
        bit prevCpu;
        applyReset(1'b0);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0010;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h0000_0020;
        prevCpu = 1'b0;
        for (int k = 0; k < 16; k++) begin
            expCpu = ((k / MAX_BURST) % 2) == 0;
            @(negedge clock);
            compared++; if (cpu_gnt !== expCpu) begin mismatched++; $display("[TB] FAIL rr_cpu_gnt[%0d]: got %b expected %b", k, cpu_gnt, expCpu); end
            compared++; if (dma_gnt !== !expCpu) begin mismatched++; $display("[TB] FAIL rr_dma_gnt[%0d]: got %b expected %b", k, dma_gnt, !expCpu); end
            compared++; if (cpu_stall !== !expCpu) begin mismatched++; $display("[TB] FAIL rr_cpu_stall[%0d]: got %b expected %b", k, cpu_stall, !expCpu); end
            if (k > 0) begin
                compared++; if (cpu_rvalid !== prevCpu) begin mismatched++; $display("[TB] FAIL rr_cpu_rvalid[%0d]: got %b expected %b", k, cpu_rvalid, prevCpu); end
                compared++; if (dma_rvalid !== !prevCpu) begin mismatched++; $display("[TB] FAIL rr_dma_rvalid[%0d]: got %b expected %b", k, dma_rvalid, !prevCpu); end
            end
            prevCpu = expCpu;
            nextCycle();
        end
        idleInputs();
    endtask

    task automatic test_dma_write();
        applyReset(1'b0);
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h0000_0040; dma_wdata = 32'hDEAD_BEEF;
        @(negedge clock);
        compared++; if (dma_gnt !== 1'b1) begin mismatched++; $display("[TB] FAIL wr_dma_gnt: got %b expected 1", dma_gnt); end
        compared++; if (cpu_gnt !== 1'b0) begin mismatched++; $display("[TB] FAIL wr_cpu_gnt: got %b expected 0", cpu_gnt); end
        compared++; if (mem_we !== 1'b1) begin mismatched++; $display("[TB] FAIL wr_mem_we: got %b expected 1", mem_we); end
        compared++; if (mem_addr !== 32'h0000_0040) begin mismatched++; $display("[TB] FAIL wr_mem_addr: got %h expected 00000040", mem_addr); end
        compared++; if (mem_wdata !== 32'hDEAD_BEEF) begin mismatched++; $display("[TB] FAIL wr_mem_wdata: got %h expected deadbeef", mem_wdata); end
        refMem[10'h040] = 32'hDEAD_BEEF;
        nextCycle();
        dma_req = 1'b0; dma_we = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0040;
        @(negedge clock);
        compared++; if (dma_rvalid !== 1'b0) begin mismatched++; $display("[TB] FAIL wr_dma_rvalid: got %b expected 0", dma_rvalid); end
        compared++; if (cpu_rvalid !== 1'b0) begin mismatched++; $display("[TB] FAIL wr_cpu_rvalid: got %b expected 0", cpu_rvalid); end
        compared++; if (cpu_gnt !== 1'b1) begin mismatched++; $display("[TB] FAIL wr_readback_gnt: got %b expected 1", cpu_gnt); end
        nextCycle();
        cpu_req = 1'b0;
        @(negedge clock);
        compared++; if (cpu_rvalid !== 1'b1) begin mismatched++; $display("[TB] FAIL wr_readback_rvalid: got %b expected 1", cpu_rvalid); end
        compared++; if (rdata !== 32'hDEAD_BEEF) begin mismatched++; $display("[TB] FAIL wr_readback_data: got %h expected deadbeef", rdata); end
        nextCycle();
        idleInputs();
    endtask

    task automatic test_reset_mid_read();
        applyReset(1'b0);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0100;
        @(negedge clock);
        compared++; if (cpu_gnt !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_cpu_gnt: got %b expected 1", cpu_gnt); end
        nextCycle();
        cpu_req = 1'b0;
        reset   = 1'b1;
        @(negedge clock);
        compared++; if (cpu_rvalid !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_reset_rvalid: got %b expected 0", cpu_rvalid); end
        nextCycle();
        reset = 1'b0;
        cpu_req = 1'b1; cpu_addr = 32'h0000_0104;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h0000_0200;
        @(negedge clock);
        compared++; if (cpu_rvalid !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_post_rvalid: got %b expected 0", cpu_rvalid); end
        compared++; if (cpu_gnt !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_post_cpu_gnt: got %b expected 1", cpu_gnt); end
        compared++; if (dma_gnt !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_post_dma_gnt: got %b expected 0", dma_gnt); end
        nextCycle();
        idleInputs();
    endtask

    task automatic test_random();
        bit          cPend, dPend, cWe, dWe;
        logic [31:0] cAddr, dAddr, cData, dData;
        bit          expCpuRv, expDmaRv;
        logic [31:0] expRd, expAddr, expWdata;
        bit          expWe;
        int          w;
        int          cpuWaitModel, dmaWaitModel;
        applyReset(1'b1);
        cPend = 1'b0; dPend = 1'b0; cWe = 1'b0; dWe = 1'b0;
        cAddr = '0; dAddr = '0; cData = '0; dData = '0;
        expCpuRv = 1'b0; expDmaRv = 1'b0; expRd = '0;
        cpuWaitModel = 0; dmaWaitModel = 0;
        for (int n = 0; n < 600; n++) begin
            if (cPend && $urandom_range(0, 99) < 3) cPend = 1'b0;
            if (dPend && $urandom_range(0, 99) < 3) dPend = 1'b0;
            if (!cPend && $urandom_range(0, 99) < 60) begin
                cPend = 1'b1; cWe = 1'($urandom_range(0, 1)); cAddr = $urandom; cData = $urandom;
            end
            if (!dPend && $urandom_range(0, 99) < 60) begin
                dPend = 1'b1; dWe = 1'($urandom_range(0, 1)); dAddr = $urandom; dData = $urandom;
            end
            cpu_req = cPend; cpu_we = cWe; cpu_addr = cAddr; cpu_wdata = cData;
            dma_req = dPend; dma_we = dWe; dma_addr = dAddr; dma_wdata = dData;
            w = modelWinner(cPend, dPend);
            expAddr = '0; expWe = 1'b0; expWdata = '0;
            if (w == 0) begin expAddr = cAddr; expWe = cWe; expWdata = cData; end
            if (w == 1) begin expAddr = dAddr; expWe = dWe; expWdata = dData; end
            @(negedge clock);
            compared++; if (cpu_gnt !== 1'(w == 0)) begin mismatched++; $display("[TB] FAIL rnd_cpu_gnt[%0d]: got %b expected %b", n, cpu_gnt, w == 0); end
            compared++; if (dma_gnt !== 1'(w == 1)) begin mismatched++; $display("[TB] FAIL rnd_dma_gnt[%0d]: got %b expected %b", n, dma_gnt, w == 1); end
            compared++; if (cpu_stall !== 1'(cPend && w != 0)) begin mismatched++; $display("[TB] FAIL rnd_cpu_stall[%0d]: got %b expected %b", n, cpu_stall, cPend && w != 0); end
            compared++; if (mem_addr !== expAddr) begin mismatched++; $display("[TB] FAIL rnd_mem_addr[%0d]: got %h expected %h", n, mem_addr, expAddr); end
            compared++; if (mem_we !== expWe) begin mismatched++; $display("[TB] FAIL rnd_mem_we[%0d]: got %b expected %b", n, mem_we, expWe); end
            compared++; if (mem_wdata !== expWdata) begin mismatched++; $display("[TB] FAIL rnd_mem_wdata[%0d]: got %h expected %h", n, mem_wdata, expWdata); end
            compared++; if (cpu_rvalid !== expCpuRv) begin mismatched++; $display("[TB] FAIL rnd_cpu_rvalid[%0d]: got %b expected %b", n, cpu_rvalid, expCpuRv); end
            compared++; if (dma_rvalid !== expDmaRv) begin mismatched++; $display("[TB] FAIL rnd_dma_rvalid[%0d]: got %b expected %b", n, dma_rvalid, expDmaRv); end
            if (expCpuRv || expDmaRv) begin
                compared++; if (rdata !== expRd) begin mismatched++; $display("[TB] FAIL rnd_rdata[%0d]: got %h expected %h", n, rdata, expRd); end
            end
            hist.push_back(w);
            expCpuRv = 1'b0;
            expDmaRv = 1'b0;
            if (w == 0) begin
                if (cWe) refMem[cAddr[9:0]] = cData;
                else begin expCpuRv = 1'b1; expRd = refMem[cAddr[9:0]]; end
                cPend = 1'b0;
            end else if (cPend) begin
                cpuWaitModel++;
            end
            if (w == 1) begin
                if (dWe) refMem[dAddr[9:0]] = dData;
                else begin expDmaRv = 1'b1; expRd = refMem[dAddr[9:0]]; end
                dPend = 1'b0;
            end else if (dPend) begin
                dmaWaitModel++;
            end
            nextCycle();
        end
        idleInputs();
        @(negedge clock);
`ifdef ARB_PERF_CNT_EN
        compared++; if (cpu_wait_cnt !== 32'(cpuWaitModel)) begin mismatched++; $display("[TB] FAIL rnd_cpu_wait_cnt: got %0d expected %0d", cpu_wait_cnt, cpuWaitModel); end
        compared++; if (dma_wait_cnt !== 32'(dmaWaitModel)) begin mismatched++; $display("[TB] FAIL rnd_dma_wait_cnt: got %0d expected %0d", dma_wait_cnt, dmaWaitModel); end
`endif
        nextCycle();
    endtask

`ifdef ARB_PERF_CNT_EN
    task automatic test_perf();
        applyReset(1'b0);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0010;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h0000_0020;
        for (int k = 0; k < 10; k++) nextCycle();
        idleInputs();
        @(negedge clock);
        compared++; if (cpu_wait_cnt !== 32'd4) begin mismatched++; $display("[TB] FAIL perf_cpu_wait_cnt: got %0d expected 4", cpu_wait_cnt); end
        compared++; if (dma_wait_cnt !== 32'd6) begin mismatched++; $display("[TB] FAIL perf_dma_wait_cnt: got %0d expected 6", dma_wait_cnt); end
        nextCycle();
    endtask
`endif

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        initEn     = 1'b0;
        loadEn     = 1'b0;
        loadAddr   = '0;
        loadData   = '0;
        idleInputs();
        test_reset();
        test_cpu_read();
        test_round_robin();
        test_dma_write();
        test_reset_mid_read();
        test_random();
`ifdef ARB_PERF_CNT_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
